lex_token_fsm: RTL and testbench
================================

Name: lex_token_fsm

Overview:
- Streaming character recogniser; successor to the single-pattern letters-then-digits identifier FSM.
- Consumes one character per valid cycle and tracks one token at a time in one of three selectable lexical patterns.
- Reports a registered accept flag, the current token length, and a one-cycle token-done pulse with the captured length.
- Keeps a running match counter; sits between the character source (UART/testbench stream) and the parser/counter logic.

Parameters:
- CHAR_W, 8, character width in bits (ASCII compared in low 8 bits; upper bits must be 0 for a class hit).
- LEN_W, 6, token length counter width; saturates at 2^LEN_W-1.
- CNT_W, 16, match counter width; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  CHAR_W  input character.
- char_valid  in  1  char_in is consumed this cycle when 1.
- mode  in  2  pattern select: 0=LD letters+digits+, 1=ID [A-Za-z_][A-Za-z0-9_]*, 2=NUM [0-9]+, 3=same as 0.
- clear  in  1  synchronous flush: state to IDLE, all counters and flags to 0.
- out  out  1  registered; 1 while the consumed prefix is an accepted token.
- tok_len  out  LEN_W  characters in the current token (0 in IDLE).
- len_sat  out  1  current token length has saturated.
- tok_done  out  1  one-cycle pulse: an accepted token was just terminated.
- tok_len_last  out  LEN_W  length of the last terminated accepted token.
- match_cnt  out  CNT_W  number of tok_done pulses since reset/clear.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, mode_q=0; all outputs 0.
- Classes: L = a-z/A-Z, U = '_', D = 0-9, O = anything else.
- States: IDLE, HEAD, TAIL.
- All transitions and counter updates occur only on clk edges with char_valid=1; char_valid=0 holds everything except tok_done, which is 0.
- clear has priority over char_valid.
- mode_q is latched from mode on any valid char consumed in IDLE; HEAD/TAIL use mode_q. A mid-token mode change takes effect only at the next token start.
- Mode 0 / 3 (LD):
  - IDLE: L -> HEAD; else IDLE.
  - HEAD: L -> HEAD; D -> TAIL; else IDLE.
  - TAIL: D -> TAIL; else IDLE.
  - Accepting state: TAIL.
- Mode 1 (ID):
  - IDLE: L|U -> HEAD; else IDLE.
  - HEAD: L|U|D -> HEAD; else IDLE.
  - Accepting state: HEAD.
- Mode 2 (NUM):
  - IDLE: D -> TAIL; else IDLE.
  - TAIL: D -> TAIL; else IDLE.
  - Accepting state: TAIL.
- The character that forces a return to IDLE is consumed. It is not re-evaluated as the start of a new token.
- out = (next state is accepting in mode_q), registered, so it is visible the cycle after the char edge. Latency is 1 cycle.
- tok_len:
  - Set to 1 on the char entering HEAD/TAIL from IDLE.
  - +1 per further in-token char, saturating at max.
  - len_sat=1 once at max.
  - Returns to 0 on entering IDLE.
  - Saturation does not stop recognition.
- tok_done=1 for exactly one cycle after an edge that leaves an accepting state to IDLE due to a valid char. On the same edge:
  - tok_len_last <= old tok_len (saturated value if saturated);
  - match_cnt <= match_cnt+1 (wraps).
- Leaving a non-accepting state (e.g. LD HEAD -> IDLE) gives no tok_done.
- clear does not generate tok_done.
- A token still open at the end of the stream never pulses tok_done; out stays 1 until a terminator arrives.

Decomposition:
- Shared package lex_pkg:
  - state encoding (IDLE/HEAD/TAIL);
  - mode constants (MODE_LD, MODE_ID, MODE_NUM);
  - character-class enum.
- One natural sub-module: lex_char_class, purely combinational, char_in -> class (L/U/D/O). It is reusable by the parser.

Test Plan:
- Mode 0, stream "ab12" then " " -> out=0,0,1,1 after each char. After " ": out=0, tok_done pulse, tok_len_last=4, match_cnt=1.
- Mode 0, "a1b2" -> out=0,1,0,0. The 'b' terminates and is not reused, so the trailing '2' stays IDLE. tok_done once, tok_len_last=2.
- Mode 1, "_x9" then "-" -> out=1,1,1. tok_done with tok_len_last=3. Mode 2 with "12a" -> tok_done with tok_len_last=2.
- LEN_W=3, mode 2, 10 digits then ' ' -> tok_len holds 7, len_sat=1, out stays 1. tok_done with tok_len_last=7.
- char_valid gaps plus mode change mid-token: mode 0 "ab", switch mode to 2, "3" -> still LD semantics, out=1.
- rst_n asserted mid-token: all outputs 0 immediately without a clock. clear mid-token: state IDLE next cycle, no tok_done, match_cnt=0.

Source files
------------

// File: rtl/lex_pkg.sv
// rtl/lex_pkg.sv - shared state, mode and character-class definitions for the lexer
package lex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_TAIL = 2'd2
    } lex_state_t;

    typedef enum logic [1:0] {
        CC_L = 2'd0,
        CC_U = 2'd1,
        CC_D = 2'd2,
        CC_O = 2'd3
    } char_class_t;

    localparam logic [1:0] MODE_LD  = 2'd0;
    localparam logic [1:0] MODE_ID  = 2'd1;
    localparam logic [1:0] MODE_NUM = 2'd2;

    // ID accepts in HEAD; LD (modes 0 and 3) and NUM accept in TAIL.
    function automatic logic is_accepting(input lex_state_t s, input logic [1:0] m);
        return (m == MODE_ID) ? (s == ST_HEAD) : (s == ST_TAIL);
    endfunction

endpackage

// File: rtl/lex_char_class.sv
// rtl/lex_char_class.sv - combinational ASCII classifier: letter, underscore, digit, other
module lex_char_class
    import lex_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] char_i,
    output char_class_t       class_o
);

    logic [7:0] lo;
    logic       hi_zero;

    assign lo      = char_i[7:0];
    assign hi_zero = ((char_i >> 8) == '0);

    always_comb begin
        class_o = CC_O;
        if (hi_zero) begin
            if ((lo >= 8'h61 && lo <= 8'h7a) || (lo >= 8'h41 && lo <= 8'h5a))
                class_o = CC_L;
            else if (lo == 8'h5f)
                class_o = CC_U;
            else if (lo >= 8'h30 && lo <= 8'h39)
                class_o = CC_D;
        end
    end

endmodule

// File: rtl/lex_token_fsm.sv
// rtl/lex_token_fsm.sv - streaming token recogniser with length tracking and match counting
module lex_token_fsm
    import lex_pkg::*;
#(
    parameter int CHAR_W = 8,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              char_valid,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic              out,
    output logic [LEN_W-1:0]  tok_len,
    output logic              len_sat,
    output logic              tok_done,
    output logic [LEN_W-1:0]  tok_len_last,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lex_state_t       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    char_class_t      cls;
    logic [1:0]       eff_mode;
    logic             is_id, is_num;

    lex_char_class #(.CHAR_W(CHAR_W)) u_class (
        .char_i  (char_in),
        .class_o (cls)
    );

    // A token start samples the live mode; an open token keeps the latched one.
    assign eff_mode = (state_q == ST_IDLE) ? mode : mode_q;
    assign is_id    = (eff_mode == MODE_ID);
    assign is_num   = (eff_mode == MODE_NUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LD;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            done_q  <= done_d;
            len_q   <= len_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (char_valid) begin
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (is_id) begin
                        if (cls == CC_L || cls == CC_U) state_d = ST_HEAD;
                    end else if (is_num) begin
                        if (cls == CC_D) state_d = ST_TAIL;
                    end else begin
                        if (cls == CC_L) state_d = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (is_id) begin
                        if (cls != CC_O) state_d = ST_HEAD;
                    end else if (!is_num) begin
                        if (cls == CC_L)      state_d = ST_HEAD;
                        else if (cls == CC_D) state_d = ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (!is_id && cls == CC_D) state_d = ST_TAIL;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mode_d = mode_q;
        out_d  = out_q;
        done_d = 1'b0;
        len_d  = len_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (clear) begin
            mode_d = MODE_LD;
            out_d  = 1'b0;
            len_d  = '0;
            last_d = '0;
            cnt_d  = '0;
        end else if (char_valid) begin
            if (state_q == ST_IDLE) mode_d = mode;
            out_d = is_accepting(state_d, eff_mode);
            if (state_d == ST_IDLE)
                len_d = '0;
            else if (state_q == ST_IDLE)
                len_d = LEN_ONE;
            else if (len_q != LEN_MAX)
                len_d = len_q + LEN_ONE;
            if (state_q != ST_IDLE && state_d == ST_IDLE && is_accepting(state_q, mode_q)) begin
                done_d = 1'b1;
                last_d = len_q;
                cnt_d  = cnt_q + CNT_ONE;
            end
        end
    end

    assign out          = out_q;
    assign tok_len      = len_q;
    assign len_sat      = (len_q == LEN_MAX);
    assign tok_done     = done_q;
    assign tok_len_last = last_q;
    assign match_cnt    = cnt_q;

endmodule

// File: tb/tb_lex_token_fsm.sv
// tb/tb_lex_token_fsm.sv - directed self-checking bench for lex_token_fsm
module tb_lex_token_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_in = 8'h20;
    logic        char_valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        clear = 1'b0;

    logic        out, len_sat, tok_done;
    logic [5:0]  tok_len, tok_len_last;
    logic [15:0] match_cnt;

    logic        out_3, len_sat_3, tok_done_3;
    logic [2:0]  tok_len_3, tok_len_last_3;
    logic [15:0] match_cnt_3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lex_token_fsm #(.CHAR_W(8), .LEN_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .mode(mode), .clear(clear), .out(out), .tok_len(tok_len), .len_sat(len_sat),
        .tok_done(tok_done), .tok_len_last(tok_len_last), .match_cnt(match_cnt)
    );

    lex_token_fsm #(.CHAR_W(8), .LEN_W(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .mode(mode), .clear(clear), .out(out_3), .tok_len(tok_len_3), .len_sat(len_sat_3),
        .tok_done(tok_done_3), .tok_len_last(tok_len_last_3), .match_cnt(match_cnt_3)
    );

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        char_in = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (out !== 1'b0) begin n_err++; $display("FAIL reset_out got=%0b exp=0", out); end
        n_chk++; if (tok_len !== 6'd0) begin n_err++; $display("FAIL reset_tok_len got=%0d exp=0", tok_len); end
        n_chk++; if (tok_done !== 1'b0 || len_sat !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%0b%0b exp=00", tok_done, len_sat); end
        n_chk++; if (match_cnt !== 16'd0 || tok_len_last !== 6'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", match_cnt, tok_len_last); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ld();
        logic [7:0] s [4];
        logic       e [4];
        s = '{8'h61, 8'h62, 8'h31, 8'h32};
        e = '{1'b0, 1'b0, 1'b1, 1'b1};
        mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            n_chk++; if (out !== e[i]) begin n_err++; $display("FAIL ld_out[%0d] got=%0b exp=%0b", i, out, e[i]); end
        end
        n_chk++; if (tok_len !== 6'd4) begin n_err++; $display("FAIL ld_tok_len got=%0d exp=4", tok_len); end
        send(8'h20);
        n_chk++; if (out !== 1'b0 || tok_done !== 1'b1) begin n_err++; $display("FAIL ld_term out/done got=%0b/%0b exp=0/1", out, tok_done); end
        n_chk++; if (tok_len_last !== 6'd4 || match_cnt !== 16'd1) begin n_err++; $display("FAIL ld_last_cnt got=%0d/%0d exp=4/1", tok_len_last, match_cnt); end
        idle_cycle();
        n_chk++; if (tok_done !== 1'b0) begin n_err++; $display("FAIL ld_done_pulse got=%0b exp=0", tok_done); end
    endtask

    task automatic test_ld_no_reuse();
        logic [7:0] s [4];
        logic       e [4];
        logic       d [4];
        s = '{8'h61, 8'h31, 8'h62, 8'h32};
        e = '{1'b0, 1'b1, 1'b0, 1'b0};
        d = '{1'b0, 1'b0, 1'b1, 1'b0};
        mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            n_chk++; if (out !== e[i] || tok_done !== d[i]) begin n_err++; $display("FAIL noreuse[%0d] out/done got=%0b/%0b exp=%0b/%0b", i, out, tok_done, e[i], d[i]); end
        end
        n_chk++; if (tok_len_last !== 6'd2 || match_cnt !== 16'd2 || tok_len !== 6'd0) begin n_err++; $display("FAIL noreuse_last/cnt/len got=%0d/%0d/%0d exp=2/2/0", tok_len_last, match_cnt, tok_len); end
    endtask

    task automatic test_id_num();
        logic [7:0] s [3];
        s = '{8'h5f, 8'h78, 8'h39};
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            n_chk++; if (out !== 1'b1 || tok_len !== 6'(i + 1)) begin n_err++; $display("FAIL id[%0d] out/len got=%0b/%0d exp=1/%0d", i, out, tok_len, i + 1); end
        end
        send(8'h2d);
        n_chk++; if (tok_done !== 1'b1 || tok_len_last !== 6'd3 || match_cnt !== 16'd3) begin n_err++; $display("FAIL id_term done/last/cnt got=%0b/%0d/%0d exp=1/3/3", tok_done, tok_len_last, match_cnt); end
        mode = 2'd2;
        send(8'h61);
        n_chk++; if (out !== 1'b0 || tok_len !== 6'd0) begin n_err++; $display("FAIL num_letter_idle got=%0b/%0d exp=0/0", out, tok_len); end
        send(8'h31);
        send(8'h32);
        n_chk++; if (out !== 1'b1 || tok_len !== 6'd2) begin n_err++; $display("FAIL num_out/len got=%0b/%0d exp=1/2", out, tok_len); end
        send(8'h61);
        n_chk++; if (tok_done !== 1'b1 || tok_len_last !== 6'd2 || match_cnt !== 16'd4) begin n_err++; $display("FAIL num_term done/last/cnt got=%0b/%0d/%0d exp=1/2/4", tok_done, tok_len_last, match_cnt); end
    endtask

    task automatic test_saturation();
        mode = 2'd2;
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
        n_chk++; if (tok_len_3 !== 3'd7 || len_sat_3 !== 1'b1 || out_3 !== 1'b1) begin n_err++; $display("FAIL sat3 len/sat/out got=%0d/%0b/%0b exp=7/1/1", tok_len_3, len_sat_3, out_3); end
        n_chk++; if (tok_len !== 6'd10 || len_sat !== 1'b0) begin n_err++; $display("FAIL sat6 len/sat got=%0d/%0b exp=10/0", tok_len, len_sat); end
        send(8'h20);
        n_chk++; if (tok_done_3 !== 1'b1 || tok_len_last_3 !== 3'd7 || len_sat_3 !== 1'b0) begin n_err++; $display("FAIL sat3_term done/last/sat got=%0b/%0d/%0b exp=1/7/0", tok_done_3, tok_len_last_3, len_sat_3); end
        n_chk++; if (tok_len_last !== 6'd10 || match_cnt !== 16'd5) begin n_err++; $display("FAIL sat6_term last/cnt got=%0d/%0d exp=10/5", tok_len_last, match_cnt); end
    endtask

    task automatic test_gap_mode_change();
        mode = 2'd0;
        send(8'h61);
        idle_cycle();
        idle_cycle();
        n_chk++; if (tok_len !== 6'd1 || out !== 1'b0 || tok_done !== 1'b0) begin n_err++; $display("FAIL gap_hold len/out/done got=%0d/%0b/%0b exp=1/0/0", tok_len, out, tok_done); end
        send(8'h62);
        mode = 2'd2;
        idle_cycle();
        send(8'h33);
        n_chk++; if (out !== 1'b1 || tok_len !== 6'd3) begin n_err++; $display("FAIL mode_chg out/len got=%0b/%0d exp=1/3", out, tok_len); end
        send(8'h20);
        n_chk++; if (tok_done !== 1'b1 || tok_len_last !== 6'd3 || match_cnt !== 16'd6) begin n_err++; $display("FAIL mode_chg_term done/last/cnt got=%0b/%0d/%0d exp=1/3/6", tok_done, tok_len_last, match_cnt); end
    endtask

    task automatic test_reset_clear_mid_token();
        mode = 2'd0;
        send(8'h61);
        send(8'h31);
        n_chk++; if (out !== 1'b1) begin n_err++; $display("FAIL pre_rst_out got=%0b exp=1", out); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (out !== 1'b0 || tok_len !== 6'd0 || match_cnt !== 16'd0 || tok_len_last !== 6'd0) begin n_err++; $display("FAIL async_rst out/len/cnt/last got=%0b/%0d/%0d/%0d exp=0/0/0/0", out, tok_len, match_cnt, tok_len_last); end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h61);
        send(8'h31);
        send(8'h20);
        send(8'h62);
        send(8'h32);
        n_chk++; if (out !== 1'b1 || match_cnt !== 16'd1) begin n_err++; $display("FAIL pre_clr out/cnt got=%0b/%0d exp=1/1", out, match_cnt); end
        @(negedge clk);
        clear = 1'b1;
        char_in = 8'h20;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        char_valid = 1'b0;
        n_chk++; if (out !== 1'b0 || tok_done !== 1'b0 || tok_len !== 6'd0) begin n_err++; $display("FAIL clear out/done/len got=%0b/%0b/%0d exp=0/0/0", out, tok_done, tok_len); end
        n_chk++; if (match_cnt !== 16'd0 || tok_len_last !== 6'd0) begin n_err++; $display("FAIL clear_cnt cnt/last got=%0d/%0d exp=0/0", match_cnt, tok_len_last); end
        send(8'h33);
        n_chk++; if (out !== 1'b0 || tok_len !== 6'd0) begin n_err++; $display("FAIL post_clr_idle out/len got=%0b/%0d exp=0/0", out, tok_len); end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_ld_no_reuse();
        test_id_num();
        test_saturation();
        test_gap_mode_change();
        test_reset_clear_mid_token();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
